// File: rtl/array_model_if.sv
// Command/data bundle between a DRAM-style array controller and the array it drives.
interface array_model_if #(
  parameter int unsigned ARRAY_COL_ADDR_WIDTH = 6,
  parameter int unsigned ARRAY_ROW_ADDR_WIDTH = 16,
  parameter int unsigned ARRAY_DATA_WIDTH     = 64
) ();

  logic                            cs_n;
  logic [ARRAY_ROW_ADDR_WIDTH-1:0] raddr;
  logic                            caddr_vld_wr;
  logic [ARRAY_COL_ADDR_WIDTH-1:0] caddr_wr;
  logic                            wdata_vld;
  logic [ARRAY_DATA_WIDTH-1:0]     wdata;
  logic                            caddr_vld_rd;
  logic [ARRAY_COL_ADDR_WIDTH-1:0] caddr_rd;
  logic                            rdata_vld;
  logic [ARRAY_DATA_WIDTH-1:0]     rdata;

  modport master (
    output cs_n, raddr, caddr_vld_wr, caddr_wr, wdata_vld, wdata, caddr_vld_rd, caddr_rd,
    input  rdata_vld, rdata
  );

  modport slave (
    input  cs_n, raddr, caddr_vld_wr, caddr_wr, wdata_vld, wdata, caddr_vld_rd, caddr_rd,
    output rdata_vld, rdata
  );

endinterface

// File: rtl/array_model.sv
// Cycle-level DRAM-style array responder: stores writes, returns reads after a fixed latency,
// and flags activate/precharge/column timing violations as sticky error bits.
module array_model #(
  parameter int unsigned ARRAY_COL_ADDR_WIDTH = 6,
  parameter int unsigned ARRAY_ROW_ADDR_WIDTH = 16,
  parameter int unsigned ARRAY_DATA_WIDTH     = 64,
  parameter int unsigned MEM_ROW_BITS         = 4,
  parameter int unsigned RD_LATENCY           = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] array_tRCD_WR,
  input  logic [7:0] array_tRCD_RD,
  input  logic [7:0] array_tRAS,
  input  logic [7:0] array_tWR,
  input  logic [7:0] array_tRTP,
  input  logic [7:0] array_tRP,
  input  logic       err_clr,
  output logic [7:0] array_err,
  array_model_if.slave arr
);

  localparam int unsigned Rows = 2 ** MEM_ROW_BITS;
  localparam int unsigned Cols = 2 ** ARRAY_COL_ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StAct, StPre} state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  state_e                          state_q;
  logic [7:0]                      acnt_q;
  logic [7:0]                      hcnt_q;
  logic [ARRAY_ROW_ADDR_WIDTH-1:0] row_q;
  logic                            w_any_q, r_any_q;
  logic [7:0]                      w_last_q, r_last_q;
  logic [7:0]                      err_q;

  logic [ARRAY_DATA_WIDTH-1:0] mem [Rows][Cols];

  logic [RD_LATENCY-1:0]       vld_pipe_q;
  logic [ARRAY_DATA_WIDTH-1:0] data_pipe_q [RD_LATENCY];

  logic                    cs_low, in_act, rise, fall;
  logic [7:0]              k, r;
  logic [MEM_ROW_BITS-1:0] row_idx;
  logic                    wr_ok, rd_ok, cmd_err;
  logic [7:0]              new_err;

  always_comb begin
    cs_low  = ~arr.cs_n;
    in_act  = (state_q == StAct);
    rise    = in_act & arr.cs_n;
    fall    = ~in_act & cs_low;
    // k is the index of the current low cycle; the first sampled-low cycle is k=0.
    k       = in_act ? sat_inc(acnt_q) : 8'd0;
    r       = sat_inc(acnt_q);
    row_idx = in_act ? row_q[MEM_ROW_BITS-1:0] : arr.raddr[MEM_ROW_BITS-1:0];

    cmd_err = (arr.cs_n & (arr.caddr_vld_wr | arr.caddr_vld_rd))
            | (arr.caddr_vld_wr & arr.caddr_vld_rd)
            | (arr.wdata_vld ^ arr.caddr_vld_wr);
    wr_ok   = cs_low & arr.caddr_vld_wr & arr.wdata_vld & ~arr.caddr_vld_rd;
    rd_ok   = cs_low & arr.caddr_vld_rd & ~arr.caddr_vld_wr;

    // A threshold of 0 never trips because every compare is unsigned "less than".
    new_err    = 8'd0;
    new_err[0] = wr_ok & (k < array_tRCD_WR);
    new_err[1] = rd_ok & (k < array_tRCD_RD);
    new_err[2] = rise & (r < array_tRAS);
    new_err[3] = rise & w_any_q & ((r - w_last_q) < array_tWR);
    new_err[4] = rise & r_any_q & ((r - r_last_q) < array_tRTP);
    new_err[5] = fall & (hcnt_q < array_tRP);
    new_err[6] = cmd_err;
    new_err[7] = in_act & cs_low & (arr.raddr != row_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acnt_q   <= 8'hff;
      hcnt_q   <= 8'hff;
      row_q    <= '0;
      w_any_q  <= 1'b0;
      r_any_q  <= 1'b0;
      w_last_q <= 8'd0;
      r_last_q <= 8'd0;
      err_q    <= 8'd0;
    end else begin
      case (state_q)
        StIdle:  if (cs_low) state_q <= StAct;
        StAct:   if (arr.cs_n) state_q <= StPre;
        StPre: begin
          if (cs_low) begin
            state_q <= StAct;
          end else if (hcnt_q >= array_tRP) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (cs_low) acnt_q <= k;

      if (rise) begin
        hcnt_q <= 8'd1;
      end else if (arr.cs_n) begin
        hcnt_q <= sat_inc(hcnt_q);
      end

      if (fall) row_q <= arr.raddr;

      w_any_q <= fall ? wr_ok : (w_any_q | wr_ok);
      r_any_q <= fall ? rd_ok : (r_any_q | rd_ok);
      if (wr_ok) w_last_q <= k;
      if (rd_ok) r_last_q <= k;

      err_q <= (err_q & ~{8{err_clr}}) | new_err;
    end
  end

  // Storage is deliberately left unreset so data survives a controller reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[row_idx][arr.caddr_wr] <= arr.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) data_pipe_q[i] <= '0;
    end else begin
      vld_pipe_q[0] <= rd_ok;
      if (rd_ok) data_pipe_q[0] <= mem[row_idx][arr.caddr_rd];
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        data_pipe_q[i] <= data_pipe_q[i-1];
      end
    end
  end

  assign arr.rdata_vld = vld_pipe_q[RD_LATENCY-1];
  assign arr.rdata     = data_pipe_q[RD_LATENCY-1];
  assign array_err     = err_q;

endmodule

// File: tb/tb_array_model.sv
// Directed bench for array_model: a driver pushes expected read responses, a monitor checks them.
module tb_array_model;

  localparam int unsigned RdLat = 2;
  localparam logic [63:0] DataD = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] DataX = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DataY = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [63:0] DataZ = 64'h0000_0000_CAFE_F00D;
  localparam logic [63:0] DataW = 64'hFFFF_0000_FFFF_0000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] t_rcd_wr, t_rcd_rd, t_ras, t_wr, t_rtp, t_rp;
  logic       err_clr;
  logic [7:0] err;

  array_model_if #(
    .ARRAY_COL_ADDR_WIDTH(6),
    .ARRAY_ROW_ADDR_WIDTH(16),
    .ARRAY_DATA_WIDTH    (64)
  ) bus ();

  array_model #(
    .ARRAY_COL_ADDR_WIDTH(6),
    .ARRAY_ROW_ADDR_WIDTH(16),
    .ARRAY_DATA_WIDTH    (64),
    .MEM_ROW_BITS        (4),
    .RD_LATENCY          (RdLat)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .array_tRCD_WR(t_rcd_wr),
    .array_tRCD_RD(t_rcd_rd),
    .array_tRAS   (t_ras),
    .array_tWR    (t_wr),
    .array_tRTP   (t_rtp),
    .array_tRP    (t_rp),
    .err_clr      (err_clr),
    .array_err    (err),
    .arr          (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    int          at_cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rdata_vld pulse must match the oldest pending expectation, on time.
  always @(negedge clk) begin
    if (bus.rdata_vld === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_rdata_vld: got rdata %h with no read pending (cyc %0d)",
                 bus.rdata, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rdata", bus.rdata, e.data);
        chk("rdata_cycle", 64'(cyc), 64'(e.at_cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.caddr_vld_wr = 1'b0;
    bus.wdata_vld    = 1'b0;
    bus.caddr_vld_rd = 1'b0;
    err_clr          = 1'b0;
  endtask

  task automatic low(input int n);
    bus.cs_n = 1'b0;
    repeat (n) tick();
  endtask

  task automatic high(input int n);
    bus.cs_n = 1'b1;
    repeat (n) tick();
  endtask

  task automatic wr(input logic [5:0] col, input logic [63:0] data);
    bus.cs_n         = 1'b0;
    bus.caddr_vld_wr = 1'b1;
    bus.wdata_vld    = 1'b1;
    bus.caddr_wr     = col;
    bus.wdata        = data;
    tick();
  endtask

  // Sampled at the next edge (cyc+1); visible RdLat-1 edges after that.
  task automatic rd(input logic [5:0] col, input logic [63:0] exp, input bit expect_rsp);
    exp_t e;
    bus.cs_n         = 1'b0;
    bus.caddr_vld_rd = 1'b1;
    bus.caddr_rd     = col;
    if (expect_rsp) begin
      e.data   = exp;
      e.at_cyc = cyc + RdLat;
      q.push_back(e);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.cs_n = 1'b1;
    bus.raddr = 16'h0001;
    bus.caddr_vld_wr = 1'b0;
    bus.caddr_wr = '0;
    bus.wdata_vld = 1'b0;
    bus.wdata = '0;
    bus.caddr_vld_rd = 1'b0;
    bus.caddr_rd = '0;
    err_clr = 1'b0;
    t_rcd_wr = 8'd3; t_rcd_rd = 8'd3; t_ras = 8'd8; t_wr = 8'd2; t_rtp = 8'd2; t_rp = 8'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_err", 64'(err), 64'h0);
    chk("reset_rdata_vld", 64'(bus.rdata_vld), 64'h0);
    chk("reset_rdata", bus.rdata, 64'h0);
    rst_n = 1'b1;
    high(2);

    // Legal write at k=3, rise at k=9.
    low(3); wr(6'd5, DataD); low(5); high(1);
    chk("legal_write_err", 64'(err), 64'h00);
    high(2);

    // Read col 5, then write col 6 and read it back the very next cycle.
    low(3); rd(6'd5, DataD, 1'b1); wr(6'd6, DataX); rd(6'd6, DataX, 1'b1); low(2); high(1);
    chk("legal_read_err", 64'(err), 64'h00);
    high(2);

    // Early write sets tRCD_WR but still stores; err_clr clears.
    low(2); wr(6'd7, DataY);
    chk("trcd_wr_err", 64'(err), 64'h01);
    err_clr = 1'b1; low(1);
    chk("err_clr", 64'(err), 64'h00);
    rd(6'd7, DataY, 1'b1); low(3); high(1);
    chk("early_write_stored_err", 64'(err), 64'h00);
    high(2);

    // Short activation, then re-activate after one high cycle while clearing.
    low(5); high(1);
    chk("tras_err", 64'(err), 64'h04);
    err_clr = 1'b1; low(1);
    chk("trp_err_wins_over_clr", 64'(err), 64'h20);
    err_clr = 1'b1; low(1);
    chk("clr_after_trp", 64'(err), 64'h00);
    low(6); high(1);
    chk("full_activation_err", 64'(err), 64'h00);
    high(2);

    // Late write -> tWR on rise.
    low(7); wr(6'd3, DataZ); high(1);
    chk("twr_err", 64'(err), 64'h08);
    err_clr = 1'b1; high(1);
    chk("clr_after_twr", 64'(err), 64'h00);
    high(1);

    // Write and read strobes together: command error, neither executed.
    low(3);
    bus.caddr_vld_wr = 1'b1; bus.wdata_vld = 1'b1; bus.caddr_wr = 6'd5; bus.wdata = DataW;
    bus.caddr_vld_rd = 1'b1; bus.caddr_rd = 6'd5;
    tick();
    chk("cmd_conflict_err", 64'(err), 64'h40);
    rd(6'd5, DataD, 1'b1); low(3); high(1);
    chk("cmd_err_sticky", 64'(err), 64'h40);
    high(2);
    err_clr = 1'b1; high(1);
    chk("clr_after_cmd", 64'(err), 64'h00);

    // Reset with a read in flight: no pulse, errors cleared, storage kept.
    low(3); rd(6'd3, DataZ, 1'b0);
    rst_n = 1'b0; bus.cs_n = 1'b1;
    tick(); tick();
    chk("midreset_err", 64'(err), 64'h00);
    chk("midreset_rdata_vld", 64'(bus.rdata_vld), 64'h0);
    rst_n = 1'b1;
    high(3);

    // Row 0x0011 aliases storage row 1; a row change mid-activation sets raddr_chg.
    bus.raddr = 16'h0011;
    low(3); rd(6'd3, DataZ, 1'b1); rd(6'd5, DataD, 1'b1);
    bus.raddr = 16'h0002; low(1);
    chk("raddr_chg_err", 64'(err), 64'h80);
    bus.raddr = 16'h0011; low(2); high(1);
    chk("raddr_chg_sticky", 64'(err), 64'h80);
    high(4);

    chk("pending_reads", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
